tft_line_drawer: RTL
====================

Name: tft_line_drawer

Overview:
Upstream feeder for the TFT driver's video-RAM write port. Accepts a stream of sampled touch points and rasterises a one-pixel-wide Bresenham line from the previous point to each new point. It emits one (wr_x, wr_y, wr_data, wr_ena) write per tft_clk, so fast strokes draw as continuous lines instead of scattered dots. A pen lift breaks the stroke, so the next point starts a new stroke.

Parameters:
X_RES, 480, visible width in pixels
Y_RES, 272, visible height in lines
COORD_BITS, 12, width of every x/y coordinate
COLOR_BITS, 9, pixel colour width (3 bits per channel)

Ports:
tft_clk  in  1  pixel clock; all logic is on its rising edge
rstb  in  1  reset; synchronous, active-low
pt_valid  in  1  new touch sample is presented
pt_ready  out  1  block can accept a sample
pt_x  in  COORD_BITS  sample x
pt_y  in  COORD_BITS  sample y
pen_down  in  1  touch is active for this sample
color  in  COLOR_BITS  stroke colour, sampled when a point is accepted
wr_ena  out  1  pixel write strobe to the VRAM port
wr_x  out  COORD_BITS  pixel x
wr_y  out  COORD_BITS  pixel y
wr_data  out  COLOR_BITS  pixel colour
busy  out  1  high in SETUP and DRAW

Behaviour:
- Reset (rstb=0 at an edge): state IDLE; have_prev=0; wr_ena=0; wr_x=0; wr_y=0; wr_data=0; busy=0; pt_ready=0 during the reset cycle and 1 from the first cycle after reset.
- Reset mid-line: the line is abandoned at once and no further writes are issued.
- pt_ready=1 only in IDLE. A point is accepted on an edge where pt_valid and pt_ready are both 1.
- On acceptance, pt_x, pt_y, pen_down and color are latched.
- State machine:
  - IDLE, accept with pen_down=0: have_prev <= 0; stay in IDLE; no write.
  - IDLE, accept with pen_down=1 and have_prev=0: go to SETUP with start=end=new point, which plots a single pixel.
  - IDLE, accept with pen_down=1 and have_prev=1: go to SETUP with start=prev and end=new point.
  - SETUP (1 cycle): dx=|x1-x0|; dy=-|y1-y0|; sx,sy = +1 or -1 (+1 when the coordinate is equal); err=dx+dy. Go to DRAW.
  - DRAW: each cycle, wr_ena=1 and (wr_x,wr_y)=current point. If current==end, then next cycle wr_ena=0, state IDLE, prev <= end, have_prev <= 1. Otherwise e2=2*err; if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy. Both updates apply in the same cycle when both hold.
- Arithmetic: dx/dy are signed COORD_BITS+1; err and e2 are signed COORD_BITS+2. Overflow is not possible for any in-range coordinates.
- Latency: acceptance at edge N, first wr_ena=1 after edge N+2.
- Write count: a line emits exactly max(dx,|dy|)+1 writes on consecutive cycles, both endpoints inclusive.
- Idle outputs: outside DRAW, wr_ena=0 and wr_x/wr_y/wr_data hold their last values.
- A degenerate segment (new point == prev) gives exactly one write.
- pt_valid held high while busy: the point is not lost; it is accepted on the first IDLE cycle.

Optional Feature:
Macro LINE_CLIP_EN.
- Defined: in DRAW, any pixel with x>=X_RES or y>=Y_RES still advances the stepper but drives wr_ena=0. Line timing is unchanged.
- Undefined: every rasterised pixel is written with wr_ena=1 exactly as computed; no range check.

Test Plan:
- Reset, then accept (100,50) with pen_down=1, color=9'h1C0 -> exactly one wr_ena pulse at (100,50), data 1C0, 2 cycles after acceptance; pt_ready returns to 1 the cycle after.
- Prev (10,20), accept (14,20) -> 5 consecutive writes x=10..14, y=20; then IDLE with prev=(14,20).
- Prev (0,0), accept (2,5) -> 6 writes (0,0),(0,1),(1,2),(1,3),(2,4),(2,5).
- Prev (5,5), accept (8,8) with pen_down=0 -> no writes; the next pen_down=1 point (20,20) gives a single write at (20,20).
- Start line (0,0)->(40,0); assert rstb=0 after the 3rd write -> wr_ena=0 on the next cycle; busy=0; the next accepted point plots a single pixel.
- With LINE_CLIP_EN: prev (478,10), accept (481,10) -> 4 DRAW cycles with writes only at x=478,479; without the macro, 4 writes at x=478..481.

Source files
------------

// File: rtl/tft_line_drawer.sv
// Bresenham line rasteriser feeding the TFT video-RAM write port; optional pixel clipping under LINE_CLIP_EN.
// Latency: a point accepted at edge N gives its first registered write after edge N+2, then one pixel per tft_clk.
// Backpressure: pt_ready is high only in IDLE, so a held pt_valid waits until the current line has finished.
module tft_line_drawer #(
  parameter int X_RES      = 480,
  parameter int Y_RES      = 272,
  parameter int COORD_BITS = 12,
  parameter int COLOR_BITS = 9
) (
  input  logic                  tft_clk,
  input  logic                  rstb,
  input  logic                  pt_valid,
  output logic                  pt_ready,
  input  logic [COORD_BITS-1:0] pt_x,
  input  logic [COORD_BITS-1:0] pt_y,
  input  logic                  pen_down,
  input  logic [COLOR_BITS-1:0] color,
  output logic                  wr_ena,
  output logic [COORD_BITS-1:0] wr_x,
  output logic [COORD_BITS-1:0] wr_y,
  output logic [COLOR_BITS-1:0] wr_data,
  output logic                  busy
);

  localparam int CW = COORD_BITS;

`ifdef LINE_CLIP_EN
  localparam logic CLIP_EN = 1'b1;
`else
  localparam logic CLIP_EN = 1'b0;
`endif

  localparam logic [CW-1:0] X_LIM = CW'(X_RES);
  localparam logic [CW-1:0] Y_LIM = CW'(Y_RES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  ready_en;
  logic                  have_prev;
  logic [CW-1:0]         prev_x, prev_y;
  logic [CW-1:0]         x0, y0, x1, y1;
  logic [CW-1:0]         cur_x, cur_y;
  logic [COLOR_BITS-1:0] col_q;
  logic signed [CW:0]    dx, dy;
  logic                  sx_neg, sy_neg;
  logic signed [CW+1:0]  err;

  logic                  accept;
  logic                  at_end;
  logic                  in_range;
  logic [CW-1:0]         adx, ady;
  logic signed [CW:0]    dx_init, dy_init;
  logic signed [CW+1:0]  e2, dx_ext, dy_ext, err_step;
  logic                  step_x, step_y;

  assign pt_ready = (state_q == IDLE) && ready_en;
  assign busy     = (state_q != IDLE);
  assign accept   = pt_valid && pt_ready;
  assign at_end   = (cur_x == x1) && (cur_y == y1);
  assign in_range = (cur_x < X_LIM) && (cur_y < Y_LIM);

  // Segment setup values: absolute deltas, dy carried as a negative number.
  always_comb begin
    adx     = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
    ady     = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
    dx_init = $signed({1'b0, adx});
    dy_init = -$signed({1'b0, ady});
  end

  // One Bresenham step: both axis decisions use the same e2 taken before the update.
  always_comb begin
    e2       = err <<< 1;
    dx_ext   = {dx[CW], dx};
    dy_ext   = {dy[CW], dy};
    step_x   = (e2 >= dy_ext);
    step_y   = (e2 <= dx_ext);
    err_step = err;
    if (step_x) err_step = err_step + dy_ext;
    if (step_y) err_step = err_step + dx_ext;
  end

  // State register.
  always_ff @(posedge tft_clk) begin
    if (!rstb) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: pen-down samples start a segment, a finished segment returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && pen_down) state_d = SETUP;
      SETUP:   state_d = DRAW;
      DRAW:    if (at_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: point capture, delta setup, stepping and registered write port.
  always_ff @(posedge tft_clk) begin
    if (!rstb) begin
      ready_en  <= 1'b0;
      have_prev <= 1'b0;
      prev_x    <= '0;
      prev_y    <= '0;
      x0        <= '0;
      y0        <= '0;
      x1        <= '0;
      y1        <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      col_q     <= '0;
      dx        <= '0;
      dy        <= '0;
      sx_neg    <= 1'b0;
      sy_neg    <= 1'b0;
      err       <= '0;
      wr_ena    <= 1'b0;
      wr_x      <= '0;
      wr_y      <= '0;
      wr_data   <= '0;
    end else begin
      ready_en <= 1'b1;
      wr_ena   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            col_q <= color;
            if (!pen_down) begin
              have_prev <= 1'b0;
            end else begin
              x1 <= pt_x;
              y1 <= pt_y;
              // A fresh stroke starts and ends on the new point: a single dot.
              x0 <= have_prev ? prev_x : pt_x;
              y0 <= have_prev ? prev_y : pt_y;
            end
          end
        end
        SETUP: begin
          dx     <= dx_init;
          dy     <= dy_init;
          sx_neg <= (x1 < x0);
          sy_neg <= (y1 < y0);
          err    <= {dx_init[CW], dx_init} + {dy_init[CW], dy_init};
          cur_x  <= x0;
          cur_y  <= y0;
        end
        DRAW: begin
          // Off-screen pixels still step so line timing does not depend on clipping.
          wr_ena  <= in_range || !CLIP_EN;
          wr_x    <= cur_x;
          wr_y    <= cur_y;
          wr_data <= col_q;
          if (at_end) begin
            prev_x    <= x1;
            prev_y    <= y1;
            have_prev <= 1'b1;
          end else begin
            err <= err_step;
            if (step_x) cur_x <= sx_neg ? (cur_x - CW'(1)) : (cur_x + CW'(1));
            if (step_y) cur_y <= sy_neg ? (cur_y - CW'(1)) : (cur_y + CW'(1));
          end
        end
        default: begin
          wr_ena <= 1'b0;
        end
      endcase
    end
  end

endmodule
